// File: rtl/sw_array_controller.sv
`default_nettype none
// ============================================================================
// Module      : sw_array_controller
// Description : Job-level sequencer for the Smith-Waterman scoring systolic
//               array. Clears the array, streams target bases into it, waits
//               (with timeout) for the selected PE's valid flag and presents
//               the captured score on a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_array_controller #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 128,
    parameter int LOG_LENGTH  = 7,
    parameter int DRAIN_MAX   = LENGTH + 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LOG_LENGTH-1:0]  cfg_last_pe,
    output logic                   busy,
    input  logic                   t_valid,
    output logic                   t_ready,
    input  logic [1:0]             t_data,
    input  logic                   t_last,
    output logic                   arr_rst,
    output logic                   arr_en,
    output logic [1:0]             arr_data,
    output logic [LOG_LENGTH-1:0]  arr_sel,
    input  logic                   arr_vld,
    input  logic [SCORE_WIDTH-1:0] arr_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   res_timeout,
    output logic [CNT_WIDTH-1:0]   tgt_count
);

    // Drain counter only needs to reach DRAIN_MAX-1 before the job leaves DRAIN
    localparam int                 DRAIN_W    = $clog2(DRAIN_MAX + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               beat;
    logic               drain_expired;

    assign busy          = (state != IDLE);
    assign t_ready       = (state == LOAD);
    assign beat          = (state == LOAD) && t_valid;
    assign drain_expired = (drain_cnt == DRAIN_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = LOAD;
            LOAD:    if (beat && t_last) state_next = DRAIN;
            DRAIN:   if (arr_vld || drain_expired) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered array drive, target counting, drain timing and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_rst     <= 1'b0;
            arr_en      <= 1'b0;
            arr_data    <= 2'b00;
            arr_sel     <= '0;
            res_valid   <= 1'b0;
            res_score   <= '0;
            res_timeout <= 1'b0;
            tgt_count   <= '0;
            drain_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    arr_rst <= 1'b0;
                    arr_en  <= 1'b0;
                    if (start) begin
                        arr_sel     <= cfg_last_pe;
                        tgt_count   <= '0;
                        res_timeout <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Array leaves reset on the same edge that enters LOAD
                    arr_rst <= 1'b1;
                    arr_en  <= 1'b0;
                end
                LOAD: begin
                    if (t_valid) begin
                        arr_data <= t_data;
                        arr_en   <= 1'b1;
                        if (tgt_count != {CNT_WIDTH{1'b1}}) begin
                            tgt_count <= tgt_count + 1'b1;
                        end
                        if (t_last) begin
                            drain_cnt <= '0;
                        end
                    end else begin
                        arr_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    arr_en    <= 1'b0;
                    drain_cnt <= drain_cnt + 1'b1;
                    // A valid score takes priority over a coincident timeout
                    if (arr_vld) begin
                        res_score   <= arr_result;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                    end else if (drain_expired) begin
                        res_score   <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    arr_en <= 1'b0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        arr_rst   <= 1'b0;
                    end
                end
                default: begin
                    arr_rst <= 1'b0;
                    arr_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
